spi_slave_frame: RTL and testbench

SPI_SLAVE_FRAME -- requirements
Module: spi_slave_frame

---
 rtl/spi_slave_frame.sv | 171 +++++++++++++++++
 tb/tb_spi_slave_frame.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_frame.sv
// SPI mode-0 slave that receives and transmits a fixed-length frame of words.
// Ports:
//   sclk        SPI clock, the only clock; mosi sampled on rise, miso advances on fall
//   rst_n       asynchronous active-low reset
//   ss          active-low slave select; high asynchronously aborts/clears the frame
//   mosi/miso   serial data in/out (miso is 0 while ss is high or after the frame)
//   tx_frame    words to transmit, word k at [k*DATA_W +: DATA_W]
//   rx_word     last complete received word, with word_index its position
//   rx_valid    high for one sclk period after rx_word updates
//   rx_frame    received frame, packed like tx_frame
//   frame_done  full frame received; overrun: extra bits clocked after the frame
module spi_slave_frame #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned FRAME_WORDS = 4,
    parameter int unsigned MSB_FIRST   = 1,
    localparam int unsigned WORD_W     = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1
) (
    input  logic                          sclk,
    input  logic                          rst_n,
    input  logic                          ss,
    input  logic                          mosi,
    output logic                          miso,
    input  logic [FRAME_WORDS*DATA_W-1:0] tx_frame,
    output logic [DATA_W-1:0]             rx_word,
    output logic                          rx_valid,
    output logic [WORD_W-1:0]             word_index,
    output logic [FRAME_WORDS*DATA_W-1:0] rx_frame,
    output logic                          frame_done,
    output logic                          overrun
);

    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] word_cnt_q, word_cnt_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_done_q, frame_done_d;
    logic              overrun_q, overrun_d;
    logic              armed_q;
    logic              cap_c;
    logic [DATA_W-1:0] word_nxt_c;

    logic [DATA_W-1:0]             rx_word_q;
    logic [WORD_W-1:0]             word_index_q;
    logic [FRAME_WORDS*DATA_W-1:0] rx_frame_q;

    logic [BIT_W-1:0]  tx_bit_q;
    logic [WORD_W-1:0] tx_word_q;
    logic [DATA_W-1:0] tx_word_c;
    logic [BIT_W-1:0]  tx_sel_c;

    // Word including the bit on mosi at this rise
    assign word_nxt_c = (MSB_FIRST != 0) ? {sh_q[DATA_W-2:0], mosi}
                                         : {mosi, sh_q[DATA_W-1:1]};

    // Next-state logic for the receive FSM, evaluated for the coming sclk rise
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        sh_d         = sh_q;
        rx_valid_d   = 1'b0;
        frame_done_d = frame_done_q;
        overrun_d    = overrun_q;
        cap_c        = 1'b0;
        if (armed_q) begin
            case (state_q)
                ST_IDLE, ST_SHIFT: begin
                    state_d = ST_SHIFT;
                    sh_d    = word_nxt_c;
                    if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
                        bit_cnt_d  = '0;
                        cap_c      = 1'b1;
                        rx_valid_d = 1'b1;
                        if (word_cnt_q == WORD_W'(FRAME_WORDS - 1)) begin
                            state_d      = ST_DONE;
                            frame_done_d = 1'b1;
                            word_cnt_d   = '0;
                        end else begin
                            word_cnt_d = word_cnt_q + WORD_W'(1);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
                ST_DONE:  overrun_d = 1'b1;
                default:  state_d   = ST_IDLE;
            endcase
        end
    end

    // Frame control registers; ss high clears them and re-arms after a reset
    always_ff @(posedge sclk or negedge rst_n or posedge ss) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            sh_q         <= '0;
            rx_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            armed_q      <= 1'b0;
        end else if (ss) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            sh_q         <= '0;
            rx_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            armed_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            sh_q         <= sh_d;
            rx_valid_q   <= rx_valid_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    // Received data survives ss; only reset clears it
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            rx_word_q    <= '0;
            word_index_q <= '0;
            rx_frame_q   <= '0;
        end else if (cap_c && !ss) begin
            rx_word_q                                <= word_nxt_c;
            word_index_q                             <= word_cnt_q;
            rx_frame_q[word_cnt_q*DATA_W +: DATA_W]  <= word_nxt_c;
        end
    end

    // Transmit pointers advance on the falling edge so the next bit is set up for the rise
    always_ff @(negedge sclk or negedge rst_n or posedge ss) begin
        if (!rst_n) begin
            tx_bit_q  <= '0;
            tx_word_q <= '0;
        end else if (ss) begin
            tx_bit_q  <= '0;
            tx_word_q <= '0;
        end else if (tx_bit_q == BIT_W'(DATA_W - 1)) begin
            tx_bit_q  <= '0;
            tx_word_q <= (tx_word_q == WORD_W'(FRAME_WORDS - 1)) ? '0 : tx_word_q + WORD_W'(1);
        end else begin
            tx_bit_q  <= tx_bit_q + BIT_W'(1);
        end
    end

    assign tx_word_c = tx_frame[tx_word_q*DATA_W +: DATA_W];
    assign tx_sel_c  = (MSB_FIRST != 0) ? BIT_W'(DATA_W - 1) - tx_bit_q : tx_bit_q;

    // Combinational so the first bit appears as soon as ss falls
    assign miso = (rst_n && !ss && armed_q && (state_q != ST_DONE)) ? tx_word_c[tx_sel_c] : 1'b0;

    assign rx_word    = rx_word_q;
    assign rx_valid   = rx_valid_q;
    assign word_index = word_index_q;
    assign rx_frame   = rx_frame_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_spi_slave_frame.sv
module tb_spi_slave_frame;

    logic        sclk, rst_n, ss, ss2, mosi;
    logic        miso, miso2;
    logic [31:0] tx_frame;
    logic [7:0]  rx_word;
    logic        rx_valid, frame_done, overrun;
    logic [1:0]  word_index;
    logic [31:0] rx_frame;
    logic [31:0] tx_frame2;
    logic [15:0] rx_word2;
    logic        rx_valid2, frame_done2, overrun2;
    logic [0:0]  word_index2;
    logic [31:0] rx_frame2;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] sb[$];
    logic [15:0] exp_e;
    logic [63:0] rd;
    logic [15:0] rev;
    logic [31:0] stream;

    spi_slave_frame u_dut (
        .sclk(sclk), .rst_n(rst_n), .ss(ss), .mosi(mosi), .miso(miso),
        .tx_frame(tx_frame), .rx_word(rx_word), .rx_valid(rx_valid),
        .word_index(word_index), .rx_frame(rx_frame),
        .frame_done(frame_done), .overrun(overrun)
    );

    spi_slave_frame #(.DATA_W(16), .FRAME_WORDS(2), .MSB_FIRST(0)) u_dut2 (
        .sclk(sclk), .rst_n(rst_n), .ss(ss2), .mosi(mosi), .miso(miso2),
        .tx_frame(tx_frame2), .rx_word(rx_word2), .rx_valid(rx_valid2),
        .word_index(word_index2), .rx_frame(rx_frame2),
        .frame_done(frame_done2), .overrun(overrun2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Master: drives bits[n-1] first, samples miso just before each rise
    task automatic xfer(input logic [63:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = bits[i];
            #2;
            rd = {rd[62:0], miso};
            sclk = 1'b1;
            #3;
            sclk = 1'b0;
            #5;
        end
    endtask

    task automatic push_word(input logic [7:0] data, input logic [7:0] idx);
        sb.push_back({idx, data});
    endtask

    // Scoreboard monitor for the default instance
    always begin
        @(posedge sclk);
        #1;
        if (rx_valid) begin
            check("sb_avail", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp_e = sb.pop_front();
                check("rx_word", 64'(rx_word), 64'(exp_e[7:0]));
                check("word_idx", 64'(word_index), 64'(exp_e[15:8]));
            end
        end
    end

    initial begin
        sclk = 1'b0; rst_n = 1'b0; ss = 1'b0; ss2 = 1'b0; mosi = 1'b0;
        tx_frame  = {8'h78, 8'h56, 8'h34, 8'h12};
        tx_frame2 = 32'h0;
        rd = '0;

        // Reset with ss low and mosi toggling
        xfer(64'h2A, 6);
        check("rst_rx_word", 64'(rx_word), 64'd0);
        check("rst_rx_valid", 64'(rx_valid), 64'd0);
        check("rst_word_index", 64'(word_index), 64'd0);
        check("rst_rx_frame", 64'(rx_frame), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_miso", 64'(miso), 64'd0);
        rst_n = 1'b1;
        #5;
        ss = 1'b1; ss2 = 1'b1;
        #10;
        check("ss_high_miso", 64'(miso), 64'd0);
        check("ss_high_miso2", 64'(miso2), 64'd0);
        ss = 1'b0;
        #5;
        check("idle_state", 64'(u_dut.state_q), 64'd0);

        // Full frame A5,3C,0F,F0 with MISO readback
        push_word(8'hA5, 8'd0); push_word(8'h3C, 8'd1);
        push_word(8'h0F, 8'd2); push_word(8'hF0, 8'd3);
        rd = '0;
        stream = 32'hA53C0FF0;
        xfer(64'(stream >> 1), 31);
        check("fd_before_last", 64'(frame_done), 64'd0);
        xfer(64'(stream[0]), 1);
        check("fd_at_32", 64'(frame_done), 64'd1);
        check("ovr_at_32", 64'(overrun), 64'd0);
        check("miso_read", 64'(rd[31:0]), 64'h12345678);
        check("rx_frame", 64'(rx_frame), 64'hF00F3CA5);
        check("miso_done", 64'(miso), 64'd0);

        // Eight extra edges: overrun, nothing else moves
        xfer(64'h00, 1);
        check("ovr_at_33", 64'(overrun), 64'd1);
        xfer(64'hFF, 7);
        check("ovr_sticky", 64'(overrun), 64'd1);
        check("fd_hold", 64'(frame_done), 64'd1);
        check("rx_frame_hold", 64'(rx_frame), 64'hF00F3CA5);
        check("rx_word_hold", 64'(rx_word), 64'hF0);
        check("idx_hold", 64'(word_index), 64'd3);
        check("valid_done", 64'(rx_valid), 64'd0);
        ss = 1'b1;
        #5;
        check("fd_clear", 64'(frame_done), 64'd0);
        check("ovr_clear", 64'(overrun), 64'd0);
        check("ss_keep_word", 64'(rx_word), 64'hF0);
        #5;

        // Abort after 12 bits, then new frame
        ss = 1'b0;
        #5;
        push_word(8'hA5, 8'd0);
        xfer(64'hA5A, 12);
        ss = 1'b1;
        #10;
        ss = 1'b0;
        #5;
        push_word(8'h11, 8'd0); push_word(8'h22, 8'd1);
        push_word(8'h33, 8'd2); push_word(8'h44, 8'd3);
        stream = 32'h11223344;
        xfer(64'(stream >> 25), 7);
        check("abort_keep", 64'(rx_word), 64'hA5);
        xfer(64'(stream[24:0]), 25);
        check("abort_frame", 64'(rx_frame), 64'h44332211);
        check("abort_fd", 64'(frame_done), 64'd1);
        ss = 1'b1;
        #10;

        // LSB-first 16-bit instance
        ss2 = 1'b0;
        #5;
        for (int i = 0; i < 16; i++) rev[15 - i] = 16'h1234 >> i;
        xfer(64'(rev >> 1), 15);
        check("m2_valid_early", 64'(rx_valid2), 64'd0);
        xfer(64'(rev[0]), 1);
        check("m2_word", 64'(rx_word2), 64'h1234);
        check("m2_idx", 64'(word_index2), 64'd0);
        check("m2_valid", 64'(rx_valid2), 64'd1);
        for (int i = 0; i < 16; i++) rev[15 - i] = 16'hBEEF >> i;
        xfer(64'(rev), 16);
        check("m2_fd", 64'(frame_done2), 64'd1);
        check("m2_frame", 64'(rx_frame2), 64'hBEEF1234);
        ss2 = 1'b1;
        #10;

        // Reset mid-frame: no activity until ss toggles
        ss = 1'b0;
        #5;
        xfer(64'h5, 4);
        rst_n = 1'b0;
        #3;
        check("midrst_word", 64'(rx_word), 64'd0);
        check("midrst_frame", 64'(rx_frame), 64'd0);
        rst_n = 1'b1;
        #2;
        xfer(64'hC3, 8);
        check("midrst_noword", 64'(rx_word), 64'd0);
        check("midrst_idle", 64'(u_dut.state_q), 64'd0);
        check("midrst_miso", 64'(miso), 64'd0);
        ss = 1'b1;
        #10;
        ss = 1'b0;
        #5;
        push_word(8'h5A, 8'd0);
        xfer(64'h5A, 8);
        check("rearm_word", 64'(rx_word), 64'h5A);
        ss = 1'b1;
        #10;

        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
